load_store_unit: RTL and testbench
==================================

# load_store_unit

Initiator side of the data-memory port. Accepts one load/store request at a time from the MEM stage and drives the memory's address, write-enable, write-data and memcontrol lines. Aligned byte/half/word accesses go through as a single memory access. Misaligned halfword and word accesses are split into sequential byte accesses, and load results are reassembled and extended before a one-cycle response is returned. The MEM stage stalls on `req_ready`.

## Interface
- ADDRESS_WIDTH, 32, address width of request and memory port
- DATA_WIDTH, 32, data width (fixed at 4 bytes)
- BYTE_WIDTH, 8, byte width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDRESS_WIDTH  byte address (ALU result)
- req_wdata  in  DATA_WIDTH  store data (rs2)
- req_funct3  in  3  load/store funct3
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors
- resp_err  out  1  illegal funct3; valid with resp_valid
- mem_a  out  ADDRESS_WIDTH  memory address
- mem_we  out  1  memory write enable
- mem_writedata  out  DATA_WIDTH  memory write data
- mem_memcontrol  out  3  memory access type
- mem_readdata  in  DATA_WIDTH  combinational memory read data

## Operation
- States: IDLE, ACCESS, DONE.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`: latch we/addr/wdata/funct3 and clear the byte index and assembly register.
  - Legal loads are funct3 000/001/010/100/101. Legal stores are 000/001/010.
  - Illegal: go to DONE with err = 1 and no memory access. Otherwise go to ACCESS.
- **Misaligned** means: half with addr[0] = 1, or word with addr[1:0] ≠ 0. Byte accesses are always aligned.
  - n = 2 for a half, 4 for a word.
- **ACCESS, aligned**
  - One cycle: mem_a = addr, mem_memcontrol = funct3, mem_we = we, mem_writedata = wdata.
  - Loads capture mem_readdata unchanged, since memory has already extended it.
  - Go to DONE.
- **ACCESS, misaligned**
  - n cycles, index i = 0..n-1: mem_a = addr + i (wraps modulo 2^ADDRESS_WIDTH).
  - Stores: mem_memcontrol = 000, mem_we = 1, mem_writedata[7:0] = wdata byte i, upper bits 0.
  - Loads: mem_memcontrol = 100 (lbu), mem_we = 0; mem_readdata[7:0] is written to assembly byte i.
  - After i = n-1, go to DONE.
  - Final misaligned load value:
    - lh: sign-extend bits [15:0]; lhu: zero-extend.
    - lw: the 4 assembled bytes, little-endian (byte 0 at addr).
- **DONE**
  - `resp_valid` = 1 for exactly one cycle; `req_ready` = 0; then return to IDLE.
  - `resp_rdata`/`resp_err` are registered and stable only while `resp_valid` is high. Otherwise they are 0.
- **Memory port outside ACCESS:** mem_we = 0, mem_a = 0, mem_writedata = 0, mem_memcontrol = 010. The idle lines cause no side effects.
- **Reset**
  - Values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, index 0.
  - Reset asserted mid-ACCESS aborts at once. Bytes of a split store that were already written stay written, and no response is issued.

## Timing
- The request is accepted on the edge at the end of cycle T (req_valid & req_ready).
- Aligned: memory access in T+1, resp_valid in T+2. Latency 2, blocking.
- Misaligned: accesses in T+1..T+n, resp_valid in T+n+1.
- Illegal funct3: resp_valid in T+1, no mem_we ever.
- Throughput: the next request can be accepted no earlier than the cycle after DONE. `req_ready` is low in ACCESS and DONE.
- Changes to req_* while not in IDLE are ignored, because all request fields are latched.
- mem_we is driven from state only, never combinationally from req_*.

## Test plan
- Reset: assert rst during the second byte of a misaligned sw -> same-cycle IDLE, mem_we 0, resp_valid stays 0, req_ready 1 after release.
- Aligned lw at 0x4, mem[4..7] = 04,03,02,01 -> single access with mem_memcontrol 010 at T+1; resp_rdata 0x01020304 at T+2, resp_err 0.
- Misaligned sw 0xAABBCCDD at 0x5 -> mem_we high in T+1..T+4 with (a, data[7:0]) = (5,DD), (6,CC), (7,BB), (8,AA), memcontrol 000; resp_valid at T+5 with rdata 0.
- Misaligned lh at 0x3, mem[3] = 80, mem[4] = FF -> two lbu reads, rdata 0xFFFFFF80; repeat as lhu -> 0x0000FF80; lw at 0x6 assembles 4 bytes over 4 cycles.
- Illegal funct3 011 load and store funct3 100 -> resp_valid at T+1, resp_err 1, rdata 0, mem_we never high.
- Back-to-back: req_valid held high with two aligned sb -> req_ready low in T+1, T+2; second accepted at T+3 (after the resp at T+2), resp at T+5.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator; splits misaligned half/word accesses into byte accesses
// and reassembles load results into a one-cycle response.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    input  logic [2:0]               req_funct3,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rdata,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_writedata,
    output logic [2:0]               mem_memcontrol,
    input  logic [DATA_WIDTH-1:0]    mem_readdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t                   state;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [2:0]               f3_q;
    logic [1:0]               idx;
    logic [DATA_WIDTH-1:0]    asm_q;
    logic                     legal;
    logic                     misal;
    logic                     in_acc;
    logic [1:0]               last_idx;
    logic [DATA_WIDTH-1:0]    asm_n;
    logic [DATA_WIDTH-1:0]    load_val;

    assign legal    = req_we ? (!req_funct3[2] && req_funct3[1:0] != 2'b11)
                             : (req_funct3[1:0] != 2'b11 && !(req_funct3[2] && req_funct3[1]));
    assign misal    = (f3_q[1:0] == 2'b01 && addr_q[0]) || (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
    assign last_idx = f3_q[0] ? 2'd1 : 2'd3;
    assign in_acc   = state == ACCESS;

    always_comb begin
        asm_n = asm_q;
        asm_n[idx*BYTE_WIDTH +: BYTE_WIDTH] = mem_readdata[BYTE_WIDTH-1:0];
    end

    assign load_val = f3_q[1] ? asm_n
                    : f3_q[2] ? {{(DATA_WIDTH-16){1'b0}}, asm_n[15:0]}
                    : {{(DATA_WIDTH-16){asm_n[15]}}, asm_n[15:0]};

    assign req_ready      = state == IDLE;
    assign resp_valid     = state == DONE;
    assign mem_we         = in_acc && we_q;
    assign mem_a          = !in_acc ? '0 : misal ? addr_q + ADDRESS_WIDTH'(idx) : addr_q;
    assign mem_memcontrol = !in_acc ? 3'b010 : !misal ? f3_q : we_q ? 3'b000 : 3'b100;
    // split accesses carry one byte on the low lane only
    assign mem_writedata  = !in_acc ? '0
                          : misal ? DATA_WIDTH'(wdata_q[idx*BYTE_WIDTH +: BYTE_WIDTH]) : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            idx        <= '0;
            asm_q      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q       <= req_we;
                    addr_q     <= req_addr;
                    wdata_q    <= req_wdata;
                    f3_q       <= req_funct3;
                    idx        <= '0;
                    asm_q      <= '0;
                    resp_rdata <= '0;
                    resp_err   <= !legal;
                    state      <= legal ? ACCESS : DONE;
                end
                ACCESS: if (!misal) begin
                    resp_rdata <= we_q ? '0 : mem_readdata;
                    state      <= DONE;
                end else begin
                    asm_q <= asm_n;
                    idx   <= idx + 2'd1;
                    if (idx == last_idx) begin
                        resp_rdata <= we_q ? '0 : load_val;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector table, directed corner sequences and randomized ops against a byte-array model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_writedata;
    logic [2:0]  mem_memcontrol;
    logic [31:0] mem_readdata;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_a(mem_a), .mem_we(mem_we), .mem_writedata(mem_writedata),
        .mem_memcontrol(mem_memcontrol), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic        init_mem = 1'b1;
    logic        bd_we = 1'b0;
    logic [7:0]  bd_a = '0;
    logic [7:0]  bd_d = '0;
    logic [7:0]  ma0, ma1, ma2, ma3;
    logic [31:0] w;

    assign ma0 = mem_a[7:0];
    assign ma1 = ma0 + 8'd1;
    assign ma2 = ma0 + 8'd2;
    assign ma3 = ma0 + 8'd3;

    // memory returns data already extended according to memcontrol
    always_comb begin
        w = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
        mem_readdata = mem_memcontrol == 3'b000 ? {{24{w[7]}}, w[7:0]}
                     : mem_memcontrol == 3'b100 ? {24'b0, w[7:0]}
                     : mem_memcontrol == 3'b001 ? {{16{w[15]}}, w[15:0]}
                     : mem_memcontrol == 3'b101 ? {16'b0, w[15:0]}
                     : mem_memcontrol == 3'b010 ? w : 32'b0;
    end

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= i == 5 ? 8'h03 : i == 6 ? 8'h02 : i == 7 ? 8'h01 : 8'(i);
        end else begin
            if (mem_we) begin
                mem[ma0] <= mem_writedata[7:0];
                if (mem_memcontrol[1:0] != 2'b00) mem[ma1] <= mem_writedata[15:8];
                if (mem_memcontrol[1:0] == 2'b10) begin
                    mem[ma2] <= mem_writedata[23:16];
                    mem[ma3] <= mem_writedata[31:24];
                end
            end
            if (bd_we) mem[bd_a] <= bd_d;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] a_log [9];
    logic [31:0] wd_log [9];
    logic [2:0]  mc_log [9];
    logic        we_log [9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        bd_we = 1'b1; bd_a = a; bd_d = d;
        step();
        bd_we = 1'b0;
    endtask

    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] f3, output int lat, output logic [31:0] rd,
                           output logic err, output int nwe);
        lat = 0; rd = '0; err = 1'b0; nwe = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
        step();
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom);
        for (int k = 1; k <= 8; k++) begin
            we_log[k] = mem_we; a_log[k] = mem_a; wd_log[k] = mem_writedata; mc_log[k] = mem_memcontrol;
            if (mem_we) nwe++;
            if (resp_valid) begin
                lat = k; rd = resp_rdata; err = resp_err;
                break;
            end
            step();
        end
        step();
        chk("idle_after", {30'b0, req_ready, resp_valid}, 32'h2);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;
    vec_t vt [19];

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
        int          size = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
        logic [31:0] v = '0;
        for (int k = 0; k < size; k++) v |= 32'(ref_mem[8'(addr + 32'(k))]) << (8 * k);
        if (!f3[2] && size < 4 && v[8*size-1]) v |= 32'hFFFF_FFFF << (8 * size);
        return v;
    endfunction

    initial begin
        int          lat, nwe, size, exp_lat, diff;
        logic [31:0] rd, exp_rd, addr, wdata;
        logic        err, we, legal, mis;
        logic [2:0]  f3;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; init_mem = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_rdata_err", resp_rdata | 32'(resp_err), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("idle_mem_port", mem_a | mem_writedata, 32'h0);
        chk("idle_memcontrol", 32'(mem_memcontrol), 32'h2);

        vt[0]  = '{1'b0, 32'h0000_0004, 32'h0, 3'd2, 32'h0102_0304, 1'b0, 2};
        vt[1]  = '{1'b0, 32'h0000_0080, 32'h0, 3'd0, 32'hFFFF_FF80, 1'b0, 2};
        vt[2]  = '{1'b0, 32'h0000_0080, 32'h0, 3'd4, 32'h0000_0080, 1'b0, 2};
        vt[3]  = '{1'b0, 32'h0000_0010, 32'h0, 3'd1, 32'h0000_1110, 1'b0, 2};
        vt[4]  = '{1'b0, 32'h0000_0081, 32'h0, 3'd1, 32'hFFFF_8281, 1'b0, 3};
        vt[5]  = '{1'b0, 32'h0000_0081, 32'h0, 3'd5, 32'h0000_8281, 1'b0, 3};
        vt[6]  = '{1'b0, 32'h0000_0021, 32'h0, 3'd2, 32'h2423_2221, 1'b0, 5};
        vt[7]  = '{1'b0, 32'h0000_0022, 32'h0, 3'd2, 32'h2524_2322, 1'b0, 5};
        vt[8]  = '{1'b0, 32'hFFFF_FFFE, 32'h0, 3'd2, 32'h0100_FFFE, 1'b0, 5};
        vt[9]  = '{1'b0, 32'h0000_00FF, 32'h0, 3'd5, 32'h0000_00FF, 1'b0, 3};
        vt[10] = '{1'b0, 32'h0000_0004, 32'h0, 3'd3, 32'h0, 1'b1, 1};
        vt[11] = '{1'b0, 32'h0000_0004, 32'h0, 3'd6, 32'h0, 1'b1, 1};
        vt[12] = '{1'b0, 32'h0000_0004, 32'h0, 3'd7, 32'h0, 1'b1, 1};
        vt[13] = '{1'b1, 32'h0000_0050, 32'h5555_5555, 3'd4, 32'h0, 1'b1, 1};
        vt[14] = '{1'b1, 32'h0000_0050, 32'h5555_5555, 3'd3, 32'h0, 1'b1, 1};
        vt[15] = '{1'b1, 32'h0000_0050, 32'h5555_5555, 3'd5, 32'h0, 1'b1, 1};
        vt[16] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 3'd2, 32'h0, 1'b0, 2};
        vt[17] = '{1'b1, 32'h0000_0045, 32'h0000_1234, 3'd1, 32'h0, 1'b0, 3};
        vt[18] = '{1'b1, 32'h0000_0047, 32'h0000_0099, 3'd0, 32'h0, 1'b0, 2};
        for (int i = 0; i < 19; i++) begin
            run_req(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].f3, lat, rd, err, nwe);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vt[i].err));
            chk($sformatf("vec%0d_nwe", i), 32'(nwe), (vt[i].we && !vt[i].err) ? 32'(vt[i].lat - 1) : 32'h0);
            if (vt[i].lat == 2 && !vt[i].err)
                chk($sformatf("vec%0d_aligned_port", i), {mc_log[1], a_log[1][28:0]}, {vt[i].f3, vt[i].addr[28:0]});
        end
        chk("store_bytes_40", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'hDEAD_BEEF);
        chk("store_bytes_44", {mem[8'h47], mem[8'h46], mem[8'h45], mem[8'h44]}, 32'h9912_3444);

        run_req(1'b1, 32'h5, 32'hAABB_CCDD, 3'd2, lat, rd, err, nwe);
        chk("sw5_lat", 32'(lat), 32'd5);
        chk("sw5_rdata", rd, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("sw5_we%0d", k), 32'(we_log[k]), 32'h1);
            chk($sformatf("sw5_a%0d", k), a_log[k], 32'(4 + k));
            chk($sformatf("sw5_wd%0d", k), wd_log[k], 32'hAABB_CCDD >> (8 * (k - 1)) & 32'hFF);
            chk($sformatf("sw5_mc%0d", k), 32'(mc_log[k]), 32'h0);
        end

        poke(8'h03, 8'h80);
        poke(8'h04, 8'hFF);
        run_req(1'b0, 32'h3, 32'h0, 3'd1, lat, rd, err, nwe);
        chk("lh3_rdata", rd, 32'hFFFF_FF80);
        chk("lh3_lat", 32'(lat), 32'd3);
        chk("lh3_port", {5'b0, mc_log[1], mc_log[2], a_log[1][7:0], a_log[2][7:0]}, {5'b0, 3'd4, 3'd4, 8'h03, 8'h04});
        run_req(1'b0, 32'h3, 32'h0, 3'd5, lat, rd, err, nwe);
        chk("lhu3_rdata", rd, 32'h0000_FF80);
        run_req(1'b0, 32'h6, 32'h0, 3'd2, lat, rd, err, nwe);
        chk("lw6_rdata", rd, 32'h09AA_BBCC);
        chk("lw6_lat", 32'(lat), 32'd5);
        chk("lw6_mc", {20'b0, mc_log[1], mc_log[2], mc_log[3], mc_log[4]}, {20'b0, 12'o4444});

        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h61; req_wdata = 32'h1122_3344; req_funct3 = 3'd2;
        step();
        req_valid = 1'b0;
        step();
        chk("rst_mid_we_before", {31'b0, mem_we}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", 32'(mem_we), 32'h0);
        chk("rst_mid_resp", 32'(resp_valid), 32'h0);
        chk("rst_mid_mem_a", mem_a, 32'h0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rst_after", {30'b0, req_ready, resp_valid}, 32'h2);
            step();
        end
        chk("rst_partial", {16'b0, mem[8'h61], mem[8'h62]}, 32'h4462);

        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h70; req_wdata = 32'hA1;
        chk("b2b_T_ready", 32'(req_ready), 32'h1);
        step();
        chk("b2b_T1", {29'b0, req_ready, mem_we, resp_valid}, 32'h2);
        chk("b2b_T1_a", mem_a, 32'h70);
        req_addr = 32'h71; req_wdata = 32'hB2;
        step();
        chk("b2b_T2", {30'b0, req_ready, resp_valid}, 32'h1);
        step();
        chk("b2b_T3", {29'b0, req_ready, mem_we, resp_valid}, 32'h4);
        step();
        req_valid = 1'b0;
        chk("b2b_T4", {29'b0, req_ready, mem_we, resp_valid}, 32'h2);
        chk("b2b_T4_a", mem_a, 32'h71);
        step();
        chk("b2b_T5", {30'b0, req_ready, resp_valid}, 32'h1);
        step();
        chk("b2b_mem", {16'b0, mem[8'h70], mem[8'h71]}, 32'hA1B2);

        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom); addr = $urandom; wdata = $urandom; f3 = 3'($urandom_range(0, 7));
            size  = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
            legal = f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || (!we && (f3 == 3'd4 || f3 == 3'd5));
            mis   = (size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0);
            exp_lat = !legal ? 1 : mis ? size + 1 : 2;
            exp_rd  = (legal && !we) ? ref_load(addr, f3) : 32'h0;
            if (legal && we)
                for (int k = 0; k < size; k++) ref_mem[8'(addr + 32'(k))] = 8'(wdata >> (8 * k));
            run_req(we, addr, wdata, f3, lat, rd, err, nwe);
            chk("rnd_lat", 32'(lat), 32'(exp_lat));
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_err", 32'(err), 32'(!legal));
            diff = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diff++;
            chk("rnd_mem", 32'(diff), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
